// File: rtl/sc_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC select codes,
// fetch state encoding and instruction width.
package sc_pkg;

  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    PCS_SEQ = 2'b00,
    PCS_BR  = 2'b01,
    PCS_JR  = 2'b10,
    PCS_J   = 2'b11
  } pcs_e;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/sc_npc.sv
// Combinational next-PC selection: sequential, PC-relative branch, register
// jump and absolute jump, plus a raw misalignment flag for register jumps.
module sc_npc
  import sc_pkg::*;
(
  input  logic [1:0]        pcsource,
  input  logic [31:0]       pc4,
  input  logic [INST_W-1:0] inst,
  input  logic [31:0]       ra,
  output logic [31:0]       npc,
  output logic              misalign_raw
);

  pcs_e               pcs;
  logic signed [31:0] br_off;

  assign pcs    = pcs_e'(pcsource);
  assign br_off = $signed({{14{inst[15]}}, inst[15:0], 2'b00});

  always_comb begin
    npc = pc4;
    case (pcs)
      PCS_SEQ: npc = pc4;
      PCS_BR:  npc = pc4 + $unsigned(br_off);
      PCS_JR:  npc = {ra[31:2], 2'b00};
      PCS_J:   npc = {pc4[31:28], inst[25:0], 2'b00};
      default: npc = pc4;
    endcase
  end

  // Only the register jump can produce a misaligned target.
  assign misalign_raw = (pcs == PCS_JR) && (ra[1:0] != 2'b00);

endmodule

// File: rtl/sc_ifu.sv
// Instruction fetch unit: requests a word from imem, holds it until the core
// advances, then steps the PC to the selected next address.
module sc_ifu
  import sc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        pcsource,
  input  logic [31:0]       ra,
  input  logic              advance,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic [31:0]       pc,
  output logic [31:0]       pc4,
  output logic              misalign,
  output logic              imem_timeout
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       npc;
  logic              misalign_raw;

  assign pc4       = pc + 32'd4;
  assign imem_addr = pc;
  assign imem_req  = (state == S_REQ) && !reset;

  sc_npc u_npc (
    .pcsource    (pcsource),
    .pc4         (pc4),
    .inst        (inst),
    .ra          (ra),
    .npc         (npc),
    .misalign_raw(misalign_raw)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      inst         <= '0;
      inst_valid   <= 1'b0;
      misalign     <= 1'b0;
      imem_timeout <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      misalign <= 1'b0;
      case (state)
        S_REQ: begin
          if (imem_ack) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            state      <= S_HOLD;
          end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
            // Timeout latches on the same edge the counter saturates.
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WAIT_W'(MAX_WAIT - 1))
              imem_timeout <= 1'b1;
          end
        end
        S_HOLD: begin
          if (advance) begin
            pc         <= npc;
            inst_valid <= 1'b0;
            misalign   <= misalign_raw;
            wait_cnt   <= '0;
            state      <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_ifu.sv
// Scenario bench for sc_ifu: directed fetch/branch/jump/timeout/reset cases
// followed by randomized transactions against a transaction-level model.
module tb_sc_ifu;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] ra = '0;
  logic        advance = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        misalign;
  logic        imem_timeout;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_timeout;
  logic        m_mis;

  sc_ifu #(.RESET_PC(RESET_PC), .MAX_WAIT(16)) dut (
    .clock(clock), .reset(reset), .pcsource(pcsource), .ra(ra),
    .advance(advance), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst),
    .inst_valid(inst_valid), .pc(pc), .pc4(pc4), .misalign(misalign),
    .imem_timeout(imem_timeout)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_npc(input logic [1:0] s, input logic [31:0] p,
                                          input logic [31:0] i, input logic [31:0] r);
    logic [31:0] p4;
    int          off;
    p4 = p + 32'd4;
    case (s)
      2'd0: return p4;
      2'd1: begin
        off = int'($signed(i[15:0])) * 4;
        return p4 + off;
      end
      2'd2: return r & ~32'd3;
      default: return (p4 & 32'hF000_0000) | ({6'd0, i[25:0]} << 2);
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input int wait_n, input logic [31:0] word);
    imem_ack = 1'b0;
    repeat (wait_n) tick();
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    m_inst = word;
    if (wait_n >= 16) m_timeout = 1'b1;
  endtask

  task automatic adv(input logic [1:0] s, input logic [31:0] r);
    m_mis    = (s == 2'd2) && (r[1:0] != 2'b00);
    m_pc     = ref_npc(s, m_pc, m_inst, r);
    pcsource = s;
    ra       = r;
    advance  = 1'b1;
    tick();
    advance  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (3) tick();
    checks++; if (pc !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, RESET_PC); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (inst_valid !== 1'b0 || inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %b/%h expected 0/0", inst_valid, inst); end
    checks++; if (misalign !== 1'b0 || imem_timeout !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", misalign, imem_timeout); end
    reset = 1'b0;
    imem_ack = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin errors++; $display("FAIL first_fetch: got %b/%h expected 1/%h", imem_req, imem_addr, RESET_PC); end
    m_pc = RESET_PC; m_inst = '0; m_timeout = 1'b0; m_mis = 1'b0;
  endtask

  task automatic test_seq();
    fetch(0, 32'h2001_0005);
    checks++; if (inst !== 32'h2001_0005 || inst_valid !== 1'b1) begin errors++; $display("FAIL seq_load: got %h/%b expected 20010005/1", inst, inst_valid); end
    checks++; if (imem_req !== 1'b0 || pc4 !== 32'h4) begin errors++; $display("FAIL seq_hold: got req %b pc4 %h expected 0/4", imem_req, pc4); end
    adv(2'd0, 32'h0);
    checks++; if (pc !== 32'h4 || imem_addr !== 32'h4) begin errors++; $display("FAIL seq_pc: got %h/%h expected 4/4", pc, imem_addr); end
    checks++; if (inst_valid !== 1'b0 || inst !== 32'h2001_0005) begin errors++; $display("FAIL seq_retain: got %b/%h expected 0/20010005", inst_valid, inst); end
    fetch(0, 32'h1234_5678);
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL latency: got %b expected 1", inst_valid); end
  endtask

  task automatic test_branch();
    adv(2'd0, 32'h0);
    fetch(0, 32'h1000_FFFE);
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL br_setup: got %h expected 8", pc); end
    adv(2'd1, 32'h0);
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL branch: got %h expected 4", pc); end
  endtask

  task automatic test_jump();
    fetch(0, $urandom);
    adv(2'd2, 32'h1000_0000);
    checks++; if (pc !== 32'h1000_0000 || misalign !== 1'b0) begin errors++; $display("FAIL jr_aligned: got %h/%b expected 10000000/0", pc, misalign); end
    fetch(0, 32'h0800_0040);
    adv(2'd3, 32'h0);
    checks++; if (pc !== 32'h1000_0100) begin errors++; $display("FAIL jump: got %h expected 10000100", pc); end
  endtask

  task automatic test_jr_misalign();
    fetch(0, $urandom);
    adv(2'd2, 32'h0000_0103);
    checks++; if (pc !== 32'h100 || misalign !== 1'b1) begin errors++; $display("FAIL jr_mis: got %h/%b expected 100/1", pc, misalign); end
    tick();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b expected 0", misalign); end
    fetch(0, $urandom);
  endtask

  task automatic test_ignore();
    logic [31:0] held;
    held = inst;
    imem_ack = 1'b1;
    imem_rdata = ~held;
    tick();
    imem_ack = 1'b0;
    checks++; if (inst !== held || inst_valid !== 1'b1) begin errors++; $display("FAIL ack_in_hold: got %h/%b expected %h/1", inst, inst_valid, held); end
    adv(2'd0, 32'h0);
    pcsource = 2'd2; ra = 32'h0000_0ABF; advance = 1'b1;
    tick();
    advance = 1'b0;
    checks++; if (pc !== m_pc || imem_req !== 1'b1 || misalign !== 1'b0) begin errors++; $display("FAIL adv_in_req: got %h/%b/%b expected %h/1/0", pc, imem_req, misalign, m_pc); end
  endtask

  task automatic test_timeout();
    fetch(0, $urandom);
    adv(2'd0, 32'h0);
    repeat (15) tick();
    checks++; if (imem_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", imem_timeout); end
    tick();
    checks++; if (imem_timeout !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b expected 1", imem_timeout); end
    repeat (3) tick();
    fetch(0, 32'hCAFE_F00D);
    m_timeout = 1'b1;
    checks++; if (inst !== 32'hCAFE_F00D || inst_valid !== 1'b1) begin errors++; $display("FAIL timeout_load: got %h/%b expected cafef00d/1", inst, inst_valid); end
    adv(2'd0, 32'h0);
    checks++; if (imem_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", imem_timeout); end
  endtask

  task automatic test_reset_midfetch();
    fetch(0, $urandom);
    adv(2'd2, 32'h40);
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL rm_setup: got %h expected 40", pc); end
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
    tick();
    checks++; if (inst_valid !== 1'b0 || pc !== RESET_PC || inst !== 32'h0) begin errors++; $display("FAIL rm_state: got %b/%h/%h expected 0/%h/0", inst_valid, pc, inst, RESET_PC); end
    checks++; if (imem_timeout !== 1'b0) begin errors++; $display("FAIL rm_timeout: got %b expected 0", imem_timeout); end
    reset = 1'b0; imem_ack = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin errors++; $display("FAIL rm_refetch: got %b/%h expected 1/%h", imem_req, imem_addr, RESET_PC); end
    m_pc = RESET_PC; m_inst = '0; m_timeout = 1'b0;
    fetch(0, 32'h5555_AAAA);
    checks++; if (inst !== 32'h5555_AAAA || pc !== RESET_PC) begin errors++; $display("FAIL rm_fetch: got %h/%h expected 5555aaaa/%h", inst, pc, RESET_PC); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int          wait_n;
      int          hold_n;
      logic [1:0]  s;
      logic [31:0] r;
      wait_n = ($urandom_range(0, 11) == 0) ? 16 + $urandom_range(0, 3) : $urandom_range(0, 4);
      fetch(wait_n, $urandom);
      checks++; if (inst !== m_inst || inst_valid !== 1'b1) begin errors++; $display("FAIL rnd_inst[%0d]: got %h/%b expected %h/1", n, inst, inst_valid, m_inst); end
      checks++; if (pc !== m_pc || pc4 !== m_pc + 32'd4 || misalign !== 1'b0) begin errors++; $display("FAIL rnd_pc[%0d]: got %h/%h/%b expected %h/%h/0", n, pc, pc4, misalign, m_pc, m_pc + 32'd4); end
      checks++; if (imem_timeout !== m_timeout) begin errors++; $display("FAIL rnd_timeout[%0d]: got %b expected %b", n, imem_timeout, m_timeout); end
      hold_n = $urandom_range(0, 3);
      for (int h = 0; h < hold_n; h++) begin
        imem_ack = 1'($urandom); imem_rdata = $urandom;
        tick();
      end
      imem_ack = 1'b0;
      s = 2'($urandom);
      r = $urandom;
      if ($urandom_range(0, 1) == 0) r[1:0] = 2'b00;
      adv(s, r);
      checks++; if (pc !== m_pc || imem_addr !== m_pc || inst_valid !== 1'b0) begin errors++; $display("FAIL rnd_npc[%0d]: sel %0d got %h/%h/%b expected %h", n, s, pc, imem_addr, inst_valid, m_pc); end
      checks++; if (misalign !== m_mis) begin errors++; $display("FAIL rnd_mis[%0d]: got %b expected %b", n, misalign, m_mis); end
    end
  endtask

  initial begin
    m_pc = RESET_PC; m_inst = '0; m_timeout = 1'b0; m_mis = 1'b0;
    test_reset();
    test_seq();
    test_branch();
    test_jump();
    test_jr_misalign();
    test_ignore();
    test_timeout();
    test_reset_midfetch();
    test_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
